compl_mul_arbiter: RTL and testbench



---
 rtl/compl_mul_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/compl_mul_arbiter.sv | 164 ++++++++++++++++
 tb/tb_compl_mul_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/compl_mul_pkg.sv
// Shared types for the compl_mul arbiter: operand/result widths, operand and result bundles, FSM states.
package compl_mul_pkg;

  localparam int DATA_W = 18;
  localparam int RES_W  = 37;

  typedef struct packed {
    logic signed [DATA_W-1:0] a_i;
    logic signed [DATA_W-1:0] a_q;
    logic signed [DATA_W-1:0] b_i;
    logic signed [DATA_W-1:0] b_q;
  } cplx_op_t;

  typedef struct packed {
    logic signed [RES_W-1:0] i;
    logic signed [RES_W-1:0] q;
  } cplx_res_t;

  typedef enum logic [1:0] {INIT, RUN, DRAIN} state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after the last winner, wrapping around.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] ptr;
  logic          found;
  int            idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 1; i <= N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

  // Pointer starts at the last requester so requester 0 wins first after reset.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) ptr <= IW'(N - 1);
    else if (advance) ptr <= grant_idx;
  end

endmodule

// File: rtl/compl_mul_arbiter.sv
// Round-robin front end sharing one compl_mul among N_REQ requesters; results return tagged with the requester ID.
// Optional: define COMPL_MUL_ARB_STATS_EN for per-requester saturating grant counters on stat_grant_o.
module compl_mul_arbiter
  import compl_mul_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int MUL_LAT = 1,
  parameter int ID_W    = $clog2(N_REQ)
) (
  input  logic                      clk_i,
  input  logic                      arst_n_i,
  input  logic                      flush_i,
  input  logic [N_REQ-1:0]          req_valid_i,
  output logic [N_REQ-1:0]          req_ready_o,
  input  logic [N_REQ*DATA_W-1:0]   req_a_i_i,
  input  logic [N_REQ*DATA_W-1:0]   req_a_q_i,
  input  logic [N_REQ*DATA_W-1:0]   req_b_i_i,
  input  logic [N_REQ*DATA_W-1:0]   req_b_q_i,
  output logic                      mul_srst_o,
  output logic signed [DATA_W-1:0]  mul_a_i_o,
  output logic signed [DATA_W-1:0]  mul_a_q_o,
  output logic signed [DATA_W-1:0]  mul_b_i_o,
  output logic signed [DATA_W-1:0]  mul_b_q_o,
  input  logic signed [RES_W-1:0]   mul_i_i,
  input  logic signed [RES_W-1:0]   mul_q_i,
  output logic                      res_valid_o,
  output logic [ID_W-1:0]           res_id_o,
  output logic signed [RES_W-1:0]   res_i_o,
  output logic signed [RES_W-1:0]   res_q_o,
  output logic                      idle_o
`ifdef COMPL_MUL_ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0]       stat_grant_o
`endif
);

  state_t           state, state_nxt;
  logic             init_cnt;
  logic             grant_en, xfer, pipe_empty;
  logic [N_REQ-1:0] arb_req, grant;
  logic [ID_W-1:0]  gnt_idx;
  cplx_op_t         sel_op, op_p0;
  logic [MUL_LAT:0] vld_p;
  logic [ID_W-1:0]  id_p [MUL_LAT+1];
  logic             res_vld_p1;
  logic [ID_W-1:0]  res_id_p1;
  cplx_res_t        res_p1;

  assign grant_en    = (state == RUN) && !flush_i;
  assign arb_req     = grant_en ? req_valid_i : '0;
  assign xfer        = |grant;
  assign req_ready_o = grant;
  assign pipe_empty  = ~|vld_p;
  assign mul_srst_o  = (state == INIT);
  assign idle_o      = (state == RUN) && !xfer && pipe_empty;

  rr_arbiter #(.N(N_REQ), .IW(ID_W)) u_rr (
    .clk       (clk_i),
    .arst_n    (arst_n_i),
    .req       (arb_req),
    .advance   (xfer),
    .grant     (grant),
    .grant_idx (gnt_idx)
  );

  // INIT holds the multiplier in reset for two clocks; DRAIN waits for in-flight IDs to retire.
  always_comb begin
    state_nxt = state;
    unique case (state)
      INIT:    if (init_cnt) state_nxt = RUN;
      RUN:     if (flush_i) state_nxt = DRAIN;
      DRAIN:   if (pipe_empty) state_nxt = INIT;
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state    <= INIT;
      init_cnt <= 1'b0;
    end else begin
      state    <= state_nxt;
      init_cnt <= (state == INIT) ? ~init_cnt : 1'b0;
    end
  end

  always_comb begin
    sel_op.a_i = req_a_i_i[32'(gnt_idx)*DATA_W +: DATA_W];
    sel_op.a_q = req_a_q_i[32'(gnt_idx)*DATA_W +: DATA_W];
    sel_op.b_i = req_b_i_i[32'(gnt_idx)*DATA_W +: DATA_W];
    sel_op.b_q = req_b_q_i[32'(gnt_idx)*DATA_W +: DATA_W];
  end

  // Stage p0: issue to the multiplier; valid/ID shift alongside its latency.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      op_p0 <= '0;
      vld_p <= '0;
      for (int k = 0; k <= MUL_LAT; k++) id_p[k] <= '0;
    end else begin
      op_p0    <= xfer ? sel_op : '0;
      vld_p[0] <= xfer;
      id_p[0]  <= gnt_idx;
      for (int k = 1; k <= MUL_LAT; k++) begin
        vld_p[k] <= vld_p[k-1];
        id_p[k]  <= id_p[k-1];
      end
    end
  end

  assign mul_a_i_o = op_p0.a_i;
  assign mul_a_q_o = op_p0.a_q;
  assign mul_b_i_o = op_p0.b_i;
  assign mul_b_q_o = op_p0.b_q;

  // Stage p1: capture the multiplier output when the tail of the ID pipe is valid.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      res_vld_p1 <= 1'b0;
      res_id_p1  <= '0;
      res_p1     <= '0;
    end else begin
      res_vld_p1 <= vld_p[MUL_LAT];
      if (vld_p[MUL_LAT]) begin
        res_id_p1 <= id_p[MUL_LAT];
        res_p1.i  <= mul_i_i;
        res_p1.q  <= mul_q_i;
      end else begin
        res_id_p1 <= '0;
        res_p1    <= '0;
      end
    end
  end

  assign res_valid_o = res_vld_p1;
  assign res_id_o    = res_id_p1;
  assign res_i_o     = res_p1.i;
  assign res_q_o     = res_p1.q;

`ifdef COMPL_MUL_ARB_STATS_EN
  logic [15:0] stat_cnt [N_REQ];

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      for (int k = 0; k < N_REQ; k++) stat_cnt[k] <= '0;
    end else if (state_nxt == INIT && state != INIT) begin
      for (int k = 0; k < N_REQ; k++) stat_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < N_REQ; k++)
        if (grant[k]) stat_cnt[k] <= sat_inc16(stat_cnt[k]);
    end
  end

  always_comb begin
    stat_grant_o = '0;
    for (int k = 0; k < N_REQ; k++) stat_grant_o[16*k +: 16] = stat_cnt[k];
  end
`endif

endmodule

// File: tb/tb_compl_mul_arbiter.sv
// Bench for compl_mul_arbiter: random requesters, behavioural compl_mul stand-in, queue scoreboard.
module tb_compl_mul_arbiter;

  localparam int N_REQ   = 4;
  localparam int MUL_LAT = 1;
  localparam int ID_W    = 2;

  logic clk, arst_n, flush;
  logic [N_REQ-1:0] req_valid, req_ready;
  logic [N_REQ*18-1:0] req_a_i, req_a_q, req_b_i, req_b_q;
  logic mul_srst;
  logic signed [17:0] mul_a_i, mul_a_q, mul_b_i, mul_b_q;
  logic signed [36:0] mul_i, mul_q;
  logic res_valid;
  logic [ID_W-1:0] res_id;
  logic signed [36:0] res_i, res_q;
  logic idle;
`ifdef COMPL_MUL_ARB_STATS_EN
  logic [N_REQ*16-1:0] stat_grant;
`endif

  compl_mul_arbiter #(.N_REQ(N_REQ), .MUL_LAT(MUL_LAT), .ID_W(ID_W)) dut (
    .clk_i(clk), .arst_n_i(arst_n), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i_i(req_a_i), .req_a_q_i(req_a_q), .req_b_i_i(req_b_i), .req_b_q_i(req_b_q),
    .mul_srst_o(mul_srst),
    .mul_a_i_o(mul_a_i), .mul_a_q_o(mul_a_q), .mul_b_i_o(mul_b_i), .mul_b_q_o(mul_b_q),
    .mul_i_i(mul_i), .mul_q_i(mul_q),
    .res_valid_o(res_valid), .res_id_o(res_id), .res_i_o(res_i), .res_q_o(res_q),
    .idle_o(idle)
`ifdef COMPL_MUL_ARB_STATS_EN
    , .stat_grant_o(stat_grant)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // compl_mul stand-in: MUL_LAT register stages, synchronous reset.
  logic signed [36:0] mp_i [MUL_LAT];
  logic signed [36:0] mp_q [MUL_LAT];
  always @(posedge clk) begin
    if (mul_srst) begin
      for (int k = 0; k < MUL_LAT; k++) begin mp_i[k] <= '0; mp_q[k] <= '0; end
    end else begin
      mp_i[0] <= 37'(longint'(mul_a_i) * longint'(mul_b_i) - longint'(mul_a_q) * longint'(mul_b_q));
      mp_q[0] <= 37'(longint'(mul_a_i) * longint'(mul_b_q) + longint'(mul_a_q) * longint'(mul_b_i));
      for (int k = 1; k < MUL_LAT; k++) begin mp_i[k] <= mp_i[k-1]; mp_q[k] <= mp_q[k-1]; end
    end
  end
  assign mul_i = mp_i[MUL_LAT-1];
  assign mul_q = mp_q[MUL_LAT-1];

  // Requester operand storage.
  logic signed [17:0] oai [N_REQ];
  logic signed [17:0] oaq [N_REQ];
  logic signed [17:0] obi [N_REQ];
  logic signed [17:0] obq [N_REQ];
  always_comb begin
    req_a_i = '0; req_a_q = '0; req_b_i = '0; req_b_q = '0;
    for (int k = 0; k < N_REQ; k++) begin
      req_a_i[18*k +: 18] = oai[k];
      req_a_q[18*k +: 18] = oaq[k];
      req_b_i[18*k +: 18] = obi[k];
      req_b_q[18*k +: 18] = obq[k];
    end
  end

  typedef struct {
    int     id;
    longint re;
    longint im;
    int     due;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int rr_last;
  int gcnt [N_REQ];

  logic [N_REQ-1:0] hs_mask, snap_ready;
  int   hs_id;
  logic snap_srst, snap_idle, snap_resv, snap_mul_nz;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [N_REQ-1:0] vv, input int last);
    int k;
    for (int i = 1; i <= N_REQ; i++) begin
      k = (last + i) % N_REQ;
      if (vv[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic signed [17:0] rnd18();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return -18'sd131072;
    if (r == 1) return 18'sd131071;
    return 18'($urandom);
  endfunction

  task automatic set_ops(input int k, input int ai, input int aq, input int bi, input int bq);
    oai[k] = 18'(ai); oaq[k] = 18'(aq); obi[k] = 18'(bi); obq[k] = 18'(bq);
  endtask

  task automatic rnd_ops(input int k);
    oai[k] = rnd18(); oaq[k] = rnd18(); obi[k] = rnd18(); obq[k] = rnd18();
  endtask

  task automatic clear_counts();
    for (int k = 0; k < N_REQ; k++) gcnt[k] = 0;
  endtask

  // Sample at the falling edge, record handshakes, then move to just after the rising edge.
  task automatic step();
    exp_t e;
    int   want;
    @(negedge clk);
    snap_ready  = req_ready;
    snap_srst   = mul_srst;
    snap_idle   = idle;
    snap_resv   = res_valid;
    snap_mul_nz = (mul_a_i != 0) || (mul_a_q != 0) || (mul_b_i != 0) || (mul_b_q != 0);
    hs_mask     = req_valid & req_ready;
    hs_id       = -1;
    if (hs_mask != '0) begin
      for (int k = 0; k < N_REQ; k++) if (hs_mask[k]) hs_id = k;
      want = rr_pick(req_valid, rr_last);
      chk("grant_onehot", $countones(req_ready), 1);
      chk("grant_rr", hs_id, want);
      e.id  = hs_id;
      e.re  = longint'(oai[hs_id]) * longint'(obi[hs_id]) - longint'(oaq[hs_id]) * longint'(obq[hs_id]);
      e.im  = longint'(oai[hs_id]) * longint'(obq[hs_id]) + longint'(oaq[hs_id]) * longint'(obi[hs_id]);
      e.due = cyc + MUL_LAT + 2;
      exp_q.push_back(e);
      rr_last = hs_id;
      if (gcnt[hs_id] < 65535) gcnt[hs_id]++;
    end else if (req_ready != '0) begin
      chk("ready_without_valid", longint'(req_ready), 0);
    end
    @(posedge clk);
    #1;
  endtask

  // Transferred requesters take new operands; keep_valid forces them to request again.
  task automatic refresh(input bit keep_valid);
    for (int k = 0; k < N_REQ; k++) begin
      if (hs_mask[k]) begin
        req_valid[k] = keep_valid ? 1'b1 : ($urandom_range(0, 3) != 0);
        rnd_ops(k);
      end else if (!req_valid[k] && $urandom_range(0, 3) == 0) begin
        req_valid[k] = 1'b1;
        rnd_ops(k);
      end
    end
  endtask

  task automatic rand_phase(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      refresh(1'b0);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (res_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got res_valid=1 id=%0d, expected no result (cycle %0d)", res_id, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("res_id", longint'(res_id), e.id);
        chk("res_i", res_i, e.re);
        chk("res_q", res_q, e.im);
        chk("res_latency", cyc, e.due);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "watchdog");
  end

  int  order [5];
  int  srst_n;
  bit  resumed, drained_chk;

  initial begin
    arst_n = 1'b0; flush = 1'b0; req_valid = '0;
    for (int k = 0; k < N_REQ; k++) set_ops(k, 0, 0, 0, 0);
    rr_last = N_REQ - 1;
    clear_counts();

    repeat (3) begin
      step();
      chk("rst_srst", snap_srst, 1);
      chk("rst_ready", longint'(snap_ready), 0);
      chk("rst_res_valid", snap_resv, 0);
      chk("rst_idle", snap_idle, 0);
      chk("rst_mul_ops", snap_mul_nz, 0);
    end

    // Release with everyone requesting (1+1j)*(1+1j); nothing may be granted during INIT.
    arst_n = 1'b1;
    for (int k = 0; k < N_REQ; k++) set_ops(k, 1, 1, 1, 1);
    req_valid = '1;
    for (int c = 0; c < 2; c++) begin
      step();
      chk("init_srst", snap_srst, 1);
      chk("init_ready", longint'(snap_ready), 0);
    end

    for (int i = 0; i < 5; i++) begin
      step();
      order[i] = hs_id;
      if (i == 0) chk("run_srst", snap_srst, 0);
    end
    req_valid = '0;
    for (int i = 0; i < 5; i++) chk("rotation", order[i], i % N_REQ);
    repeat (4) step();
    chk("idle_after_drain", snap_idle, 1);

    // Requester 2 alone: (2-3j)*(4+5j) = 23-2j.
    set_ops(2, 2, -3, 4, 5);
    req_valid[2] = 1'b1;
    step();
    chk("single_grant", hs_id, 2);
    req_valid[2] = 1'b0;
    step();
    chk("idle_busy", snap_idle, 0);
    repeat (4) step();

    // Requesters 0 and 1 together: 1 must wait with its operands held.
    rnd_ops(0); rnd_ops(1);
    req_valid[0] = 1'b1; req_valid[1] = 1'b1;
    step();
    chk("hold_first", hs_id, 0);
    chk("hold_ready1", snap_ready[1], 0);
    req_valid[0] = 1'b0;
    step();
    chk("hold_second", hs_id, 1);
    req_valid[1] = 1'b0;
    repeat (4) step();

    rand_phase(300);

    // Flush pulse with three transfers in flight.
    req_valid = '1;
    for (int k = 0; k < N_REQ; k++) rnd_ops(k);
    repeat (3) begin step(); refresh(1'b1); end
    flush = 1'b1;
    clear_counts();
    step();
    chk("flush_no_grant", longint'(snap_ready), 0);
    refresh(1'b1);
    flush = 1'b0;
    srst_n = 0; resumed = 1'b0; drained_chk = 1'b0;
    for (int i = 0; i < 12 && !resumed; i++) begin
      step();
      if (snap_srst) begin
        if (!drained_chk) begin
          chk("flush_drained", exp_q.size(), 0);
          drained_chk = 1'b1;
        end
        srst_n++;
      end
      if (hs_mask != '0) begin
        resumed = 1'b1;
        chk("flush_srst_cycles", srst_n, 2);
      end
      refresh(1'b1);
    end
    chk("flush_resumed", resumed, 1);

    // Flush held high: keeps cycling DRAIN/INIT, never grants.
    flush = 1'b1;
    clear_counts();
    for (int i = 0; i < 12; i++) begin
      step();
      chk("flush_hold_no_grant", longint'(snap_ready), 0);
    end
    flush = 1'b0;
    rand_phase(100);

    // Asynchronous reset with two transfers in flight.
    req_valid = '1;
    repeat (2) begin step(); refresh(1'b1); end
    #2;
    arst_n = 1'b0;
    exp_q.delete();
    req_valid = '0;
    rr_last = N_REQ - 1;
    clear_counts();
    repeat (3) begin
      step();
      chk("mid_rst_res_valid", snap_resv, 0);
      chk("mid_rst_srst", snap_srst, 1);
      chk("mid_rst_ready", longint'(snap_ready), 0);
      chk("mid_rst_mul_ops", snap_mul_nz, 0);
`ifdef COMPL_MUL_ARB_STATS_EN
      chk("mid_rst_stats", longint'(stat_grant), 0);
`endif
    end
    arst_n = 1'b1;
    rand_phase(80);

    req_valid = '0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    chk("final_drain", exp_q.size(), 0);
`ifdef COMPL_MUL_ARB_STATS_EN
    for (int k = 0; k < N_REQ; k++) chk("stat_grant", longint'(stat_grant[16*k +: 16]), gcnt[k]);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
